ucsbece154b_fetch_arbiter: RTL

Shares the single SDRAM-controller read port between the instruction cache demand-miss path and a next-line prefetcher. Sits between the icache/prefetch-buffer refill logic and the SDRAM controller. Demand misses have strict priority and are never preempted by prefetch. Block beats are forwarded to whichever requester owns the transfer. With merge enabled, a demand miss to a block already being prefetched rides on the prefetch transfer.

---
 rtl/ucsbece154b_mem_pkg.sv | 9 +
 rtl/ucsbece154b_fetch_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/ucsbece154b_mem_pkg.sv
// ucsbece154b_mem_pkg: shared FSM/owner types and default block geometry for the fetch arbiter
package ucsbece154b_mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  typedef enum logic [1:0] {NONE, DEM, PRE} owner_t;
  localparam int BLOCK_WORDS = 4;
  localparam int LOG_BLOCK_WORDS = $clog2(BLOCK_WORDS);
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = LOG_BLOCK_WORDS + 2;
endpackage

// File: rtl/ucsbece154b_fetch_arbiter.sv
// ucsbece154b_fetch_arbiter: shares the SDRAM read port between demand misses and the next-line prefetcher
// Optional demand-on-prefetch merging is enabled by defining FETCH_ARB_MERGE_EN.
module ucsbece154b_fetch_arbiter
  import ucsbece154b_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = ucsbece154b_mem_pkg::BLOCK_WORDS,
  parameter int WORD_SIZE = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dReq,
  input  logic [31:0]                    dAddr,
  output logic                           dGrant,
  output logic                           dValid,
  output logic                           dDone,
  input  logic                           pReq,
  input  logic [31:0]                    pAddr,
  output logic                           pGrant,
  output logic                           pValid,
  output logic                           pDone,
  output logic [WORD_SIZE-1:0]           beatData,
  output logic [$clog2(BLOCK_WORDS)-1:0] beatIndex,
  output logic                           memReadRequest,
  output logic [31:0]                    memReadAddress,
  input  logic                           memDataReady,
  input  logic [WORD_SIZE-1:0]           memDataIn,
  input  logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
  output logic                           xferErr,
  output logic                           busy
);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
  state_t state;
  owner_t owner;
  logic [CW-1:0] cnt;
  logic [31:0] addr;
  logic merged, merge_now, idle_ok, dem, pre, fin, abort;
  // Grants wait for memDataReady to fall so residual beats from an aborted transfer are drained.
  assign idle_ok = reset && state == IDLE && !memDataReady;
  assign fin = state == XFER && memDataReady && cnt == LAST;
  assign abort = state == XFER && !memDataReady;
  assign dem = owner == DEM || merged || merge_now;
  assign pre = owner == PRE;
`ifdef FETCH_ARB_MERGE_EN
  localparam int TLSB = $clog2(BLOCK_WORDS) + 2;
  // Merging is only safe before any beat has been handed to the prefetcher alone.
  assign merge_now = state == REQ && pre && !merged && dReq && dAddr[TAG_MSB:TLSB] == addr[TAG_MSB:TLSB];
`else
  assign merge_now = 1'b0;
  assign merged = 1'b0;
`endif
  assign busy = state != IDLE;
  assign dGrant = (idle_ok && dReq) || merge_now;
  assign pGrant = idle_ok && !dReq && pReq;
  assign dValid = busy && memDataReady && dem;
  assign pValid = busy && memDataReady && pre;
  assign dDone = (fin || abort) && dem;
  assign pDone = (fin || abort) && pre;
  assign xferErr = abort;
  assign beatData = busy ? memDataIn : '0;
  assign beatIndex = busy ? memBlockIndex : '0;
  assign memReadRequest = state == REQ;
  assign memReadAddress = addr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= NONE;
      cnt <= '0;
      addr <= '0;
`ifdef FETCH_ARB_MERGE_EN
      merged <= 1'b0;
`endif
    end else begin
`ifdef FETCH_ARB_MERGE_EN
      merged <= (fin || abort) ? 1'b0 : (merged || merge_now);
`endif
      case (state)
        IDLE: if (idle_ok && (dReq || pReq)) begin
          state <= REQ;
          owner <= dReq ? DEM : PRE;
          addr <= dReq ? dAddr : pAddr;
          cnt <= '0;
        end
        REQ: if (memDataReady) begin
          state <= XFER;
          cnt <= cnt + CW'(1);
        end
        XFER: if (fin || abort) begin
          state <= IDLE;
          owner <= NONE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule
